// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_STOP_BITS  = 1;
  // Serial bit slots per frame: start + payload + stop(s)
  localparam int unsigned FRAME_BITS     = 1 + DEF_DATA_WIDTH + DEF_STOP_BITS;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Modulo-CLKS_PER_BIT bit-timing counter; bit_tick_c_o flags the last cycle of a bit.
module uart_baud_gen #(
  parameter  int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             bit_tick_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_c_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign cnt_o        = cnt_q;

  // Clear wins over enable; wrap to zero on every bit boundary
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_tick_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed asynchronous serial transmitter: pops one word per frame and shifts it out LSB first.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_rd_val,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  rd_en_c;
  logic                  baud_clr;
  logic                  baud_en;
  logic                  bit_tick;
  logic [CNT_W-1:0]      baud_cnt;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (baud_clr),
    .en_i        (baud_en),
    .cnt_o       (baud_cnt),
    .bit_tick_c_o(bit_tick)
  );

  // Pops are suppressed while reset is asserted so no word is lost to an aborted frame
  assign fifo_rd_en = rd_en_c & ~reset;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    rd_en_c  = 1'b0;
    baud_clr = 1'b0;
    baud_en  = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        if (fifo_rd_val) begin
          rd_en_c = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        baud_clr = 1'b1;
        shreg_d  = fifo_rd_data;
        idx_d    = '0;
        state_d  = START;
      end
      START: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            if (fifo_rd_val) begin
              rd_en_c = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are computed for the state being entered
    tx_d = LINE_IDLE;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shreg_d[0];
    end
    busy_d       = (state_d != IDLE);
    // One cycle early: next cycle is the final cycle of the final stop bit
    frame_done_d = (state_q == STOP) &&
                   (idx_q == IDX_W'(STOP_BITS - 1)) &&
                   (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      tx_q         <= LINE_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains bytes from the team's synchronous FIFO and sends each as an asynchronous 8N1/8N2-style frame on a single line. It sits directly downstream of the FIFO: it drives the FIFO's read enable, captures the word the FIFO registers one cycle later, and shifts it out LSB first at a fixed clocks-per-bit rate.

## Interface
- DATA_WIDTH, 8: payload bits per frame; must match the FIFO's DATA_WIDTH.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- fifo_rd_val  in  1  FIFO holds at least one word.
- fifo_rd_data  in  DATA_WIDTH  FIFO read word; valid the cycle after a pop.
- fifo_rd_en  out  1  pop request to the FIFO; combinational from state and fifo_rd_val.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the LOAD cycle through the final stop-bit cycle.
- frame_done  out  1  one-cycle pulse in the final stop-bit cycle.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: tx=1, busy=0. fifo_rd_en = fifo_rd_val. If fifo_rd_val=1, go to LOAD.
- LOAD: capture fifo_rd_data into the shift register, tx=1, busy=1, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift register bit 0, held for CLKS_PER_BIT cycles. Then shift right and increment the bit index. After bit DATA_WIDTH-1, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the last cycle only.
- Last STOP cycle, fifo_rd_val=1: fifo_rd_en=1 and the next state is LOAD (back-to-back frames).
- Last STOP cycle, fifo_rd_val=0: the next state is IDLE.
- fifo_rd_en never asserts outside IDLE or the last STOP cycle, and never while fifo_rd_val=0. One pop per frame, so no FIFO underflow is possible.
- fifo_rd_val is ignored in every other state.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. It is cleared on entry to START.
- Bit index: width $clog2(DATA_WIDTH)+1. It does not wrap.
- Reset values: state IDLE, tx=1, busy=0, frame_done=0, fifo_rd_en=0 during reset, counters 0.
- Reset mid-frame aborts the frame. tx returns high the cycle after reset is sampled. A word already popped is discarded, and the FIFO is not re-read for it.

## Timing
- Pop to line: rd_en in cycle T, LOAD in T+1, start bit from T+2.
- Frame length from the first START cycle: (1 + DATA_WIDTH + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back gap: exactly one idle-high cycle (LOAD) between the last stop cycle and the next start bit.
- From IDLE: two cycles (IDLE pop, LOAD) from fifo_rd_val rising to the start bit.
- tx, busy and frame_done are registered outputs. fifo_rd_en is the only combinational output.

## Structure
- Shared package uart_pkg holds:
  - the state enum typedef (IDLE, LOAD, START, DATA, STOP);
  - the localparam for the frame bit count, 1 + DATA_WIDTH + STOP_BITS;
  - the idle-line level constant (1'b1).
- Natural sub-module: uart_baud_gen. It is a clear/enable-controlled modulo-CLKS_PER_BIT counter with a bit_tick output, reused by a future receiver.
- Top: FSM, shift register, bit index, output registers.

## Test plan
- Reset: hold reset 3 cycles with fifo_rd_val=1 -> tx=1, busy=0, frame_done=0, fifo_rd_en=0 throughout.
- Single byte: CLKS_PER_BIT=4, STOP_BITS=1, FIFO delivers 0xA5 -> tx shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. Total 40 cycles; frame_done pulses once in cycle 40.
- Back-to-back: FIFO preloaded with 0x00, 0xFF -> exactly two rd_en pulses. The second comes in frame 1's last stop cycle. Exactly one idle-high cycle separates frame 1's stop bit from frame 2's start bit.
- Empty FIFO: fifo_rd_val=0 for 100 cycles -> fifo_rd_en never asserts, tx stays 1.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=2, byte 0x80 -> stop high for 4 cycles, frame 22 cycles.
- Mid-frame reset: assert reset during data bit 3 of 0x3C -> tx=1 on the next cycle, state IDLE. A pending FIFO word is popped only after reset deasserts, and its frame is complete and correct.
